// File: rtl/tiny_cpu_pkg.sv
// Shared encodings for the tiny accumulator-style CPU: FSM states, opcodes,
// ALU function codes and the instruction byte layout.
package tiny_cpu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_EXEC  = 2'd2;
  localparam state_t S_HALT  = 2'd3;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_JZ  = 2'b11;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SUB = 2'b01;
  localparam logic [1:0] F_AND = 2'b10;
  localparam logic [1:0] F_XOR = 2'b11;

  localparam logic [7:0] INSTR_HALT = 8'hFF;

  // imm4 shares bits [3:0] with rb/func; decoders pick whichever view applies.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] func;
  } instr_t;

endpackage

// File: rtl/tiny_cpu_alu.sv
// Combinational 4-function ALU; all results wrap modulo 2^DW.
module tiny_cpu_alu
  import tiny_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    func,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    unique case (func)
      F_ADD:   y = a + b;
      F_SUB:   y = a - b;
      F_AND:   y = a & b;
      F_XOR:   y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/tiny_cpu_core_p.sv
// Two-cycle FETCH/EXEC CPU with a 4-entry register file, unified program/data
// memory, program-load port and a memory-mapped output register.
module tiny_cpu_core_p
  import tiny_cpu_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MEM_AW    = 5,
  parameter int DATA_BASE = 16,
  parameter int OUT_ADDR  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              prog_we,
  input  logic [MEM_AW-1:0] prog_addr,
  input  logic [DW-1:0]     prog_wdata,
  input  logic [1:0]        dbg_sel,
  output logic [DW-1:0]     dbg_rdata,
  output logic [7:0]        pc,
  output logic              halted,
  output logic              busy,
  output logic [DW-1:0]     out_data,
  output logic              out_valid
);

  localparam int DEPTH = 1 << MEM_AW;

  state_t            state;
  logic [7:0]        pc_q;
  logic [7:0]        instr_q;
  logic [DW-1:0]     regs [4];
  logic [DW-1:0]     mem  [DEPTH];

  instr_t            ins;
  logic [3:0]        imm;
  logic [MEM_AW-1:0] data_addr;
  logic [MEM_AW-1:0] fetch_addr;
  logic [DW-1:0]     fetch_word;
  logic [DW-1:0]     alu_y;
  logic              is_halt;
  logic              jz_taken;

  assign ins        = instr_t'(instr_q);
  assign imm        = instr_q[3:0];
  assign data_addr  = MEM_AW'(DATA_BASE) + MEM_AW'(imm);
  // pc is 8 bits; the fetch address wraps modulo the memory depth.
  assign fetch_addr = MEM_AW'(pc_q);
  assign fetch_word = mem[fetch_addr];
  assign is_halt    = (instr_q == INSTR_HALT);
  assign jz_taken   = (regs[ins.ra] == '0);

  tiny_cpu_alu #(.DW(DW)) u_alu (
    .a    (regs[ins.ra]),
    .b    (regs[ins.rb]),
    .func (ins.func),
    .y    (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (prog_we) mem[prog_addr] <= prog_wdata;
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          instr_q <= fetch_word[7:0];
          state   <= S_EXEC;
        end
        S_EXEC: begin
          // HALT wins over JZ r3,15, which shares the same byte.
          if (is_halt) begin
            state <= S_HALT;
          end else begin
            state <= run ? S_FETCH : S_IDLE;
            pc_q  <= pc_q + 8'd1;
            case (ins.op)
              OP_LD:  regs[ins.ra] <= mem[data_addr];
              OP_ST: begin
                mem[data_addr] <= regs[ins.ra];
                if (imm == 4'(OUT_ADDR)) begin
                  out_data  <= regs[ins.ra];
                  out_valid <= 1'b1;
                end
              end
              OP_ALU: regs[ins.ra] <= alu_y;
              default: if (jz_taken) pc_q <= {4'b0, imm};
            endcase
          end
        end
        default: begin
          if (!run) begin
            state <= S_IDLE;
            pc_q  <= '0;
          end
        end
      endcase
    end
  end

  assign dbg_rdata = regs[dbg_sel];
  assign pc        = pc_q;
  assign halted    = (state == S_HALT);
  assign busy      = (state == S_FETCH) || (state == S_EXEC);

endmodule

// File: tb/tb_tiny_cpu_core_p.sv
// Bench for tiny_cpu_core_p: directed scenarios plus random programs checked
// against an instruction-level reference model.
module tb_tiny_cpu_core_p;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       run, prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_wdata;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_rdata, pc, out_data;
  logic       halted, busy, out_valid;

  logic        w_run, w_prog_we;
  logic [5:0]  w_prog_addr;
  logic [15:0] w_prog_wdata;
  logic [1:0]  w_dbg_sel;
  logic [15:0] w_dbg_rdata, w_out_data;
  logic [7:0]  w_pc;
  logic        w_halted, w_busy, w_out_valid;

  tiny_cpu_core_p u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_sel(dbg_sel),
    .dbg_rdata(dbg_rdata), .pc(pc), .halted(halted), .busy(busy),
    .out_data(out_data), .out_valid(out_valid)
  );

  tiny_cpu_core_p #(.DW(16), .MEM_AW(6), .DATA_BASE(32), .OUT_ADDR(15)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .run(w_run), .prog_we(w_prog_we),
    .prog_addr(w_prog_addr), .prog_wdata(w_prog_wdata), .dbg_sel(w_dbg_sel),
    .dbg_rdata(w_dbg_rdata), .pc(w_pc), .halted(w_halted), .busy(w_busy),
    .out_data(w_out_data), .out_valid(w_out_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] img [32];

  // Instruction-level reference model state.
  int m_mem [32];
  int m_regs [4];
  int m_pc, m_out, m_outcnt, m_instrs;

  function automatic logic [7:0] enc(input int op, input int ra, input int lo4);
    return 8'((op << 6) | (ra << 4) | (lo4 & 15));
  endfunction

  function automatic logic [7:0] enc_alu(input int ra, input int rb, input int f);
    return enc(2, ra, (rb << 2) | f);
  endfunction

  task automatic model_run();
    int b, op, ra, rb, fn, imm, x, y;
    for (int i = 0; i < 32; i++) m_mem[i] = int'(img[i]);
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_pc = 0; m_out = 0; m_outcnt = 0; m_instrs = 0;
    for (int s = 0; s < 64; s++) begin
      b = m_mem[m_pc % 32] % 256;
      m_instrs++;
      if (b == 255) break;
      op = b / 64; ra = (b / 16) % 4; rb = (b / 4) % 4; fn = b % 4; imm = b % 16;
      x = m_regs[ra]; y = m_regs[rb];
      case (op)
        0: m_regs[ra] = m_mem[16 + imm];
        1: begin
          m_mem[16 + imm] = x;
          if (imm == 15) begin m_out = x; m_outcnt++; end
        end
        2: case (fn)
             0: m_regs[ra] = (x + y) % 256;
             1: m_regs[ra] = (x - y + 256) % 256;
             2: m_regs[ra] = x & y;
             default: m_regs[ra] = x ^ y;
           endcase
        default: ;
      endcase
      if (op == 3 && x == 0) m_pc = imm;
      else m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    w_run = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_image();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 5'(i); prog_wdata = img[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic clear_image(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) img[i] = fill;
    for (int i = 16; i < 32; i++) img[i] = 8'h00;
  endtask

  task automatic rd(input int r, output logic [7:0] v);
    dbg_sel = 2'(r);
    #1;
    v = dbg_rdata;
  endtask

  // Counts clock edges (from the call) until halted; timeout reported to caller.
  task automatic wait_halt(output int cycles, output int pulses, output bit timeout);
    cycles = 0; pulses = 0; timeout = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (out_valid) pulses++;
      if (halted) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    apply_reset();
    n_tests++;
    if (pc !== 8'h00 || halted !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pc=%0h halted=%0b busy=%0b out=%0h ov=%0b expected all zero",
               pc, halted, busy, out_data, out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      rd(r, v);
      n_tests++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %0h expected 0", r, v); end
    end
  endtask

  task automatic test_single_step();
    int first_ov, n_ov, first_h;
    apply_reset();
    clear_image(8'h00);
    img[16] = 8'h05;
    img[0] = enc(0, 1, 0);
    img[1] = enc(1, 1, 15);
    img[2] = 8'hFF;
    load_image();
    run = 1'b1;
    first_ov = -1; n_ov = 0; first_h = -1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin n_ov++; if (first_ov < 0) first_ov = k; end
      if (halted && first_h < 0) first_h = k;
    end
    // Edge 1 leaves IDLE, then two edges per instruction.
    n_tests++;
    if (n_ov !== 1 || first_ov !== 5) begin
      n_fail++; $display("FAIL step_out_valid: got %0d pulses first at edge %0d expected 1 at 5", n_ov, first_ov);
    end
    n_tests++;
    if (first_h !== 7) begin n_fail++; $display("FAIL step_halted: got edge %0d expected 7", first_h); end
    n_tests++;
    if (pc !== 8'd2) begin n_fail++; $display("FAIL step_pc: got %0h expected 2", pc); end
    n_tests++;
    if (out_data !== 8'h05) begin n_fail++; $display("FAIL step_out_data: got %0h expected 05", out_data); end
    run = 1'b0;
  endtask

  task automatic test_alu();
    logic [7:0] v;
    int cyc, pul; bit to;
    apply_reset();
    clear_image(8'hFF);
    img[16] = 8'd3; img[17] = 8'd7; img[18] = 8'h02; img[19] = 8'h05;
    img[0] = enc(0, 1, 0);
    img[1] = enc(0, 2, 1);
    img[2] = enc_alu(1, 2, 0);
    img[3] = enc_alu(1, 2, 1);
    img[4] = enc_alu(0, 0, 1);
    img[5] = enc(0, 1, 2);
    img[6] = enc(0, 2, 3);
    img[7] = enc_alu(1, 2, 1);
    load_image();
    run = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 7) begin
        rd(1, v); n_tests++;
        if (v !== 8'd10) begin n_fail++; $display("FAIL alu_add: got %0h expected 0a", v); end
      end
      if (k == 9) begin
        rd(1, v); n_tests++;
        if (v !== 8'd3) begin n_fail++; $display("FAIL alu_sub_back: got %0h expected 03", v); end
      end
    end
    wait_halt(cyc, pul, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL alu_halt_timeout: got no halt expected halt"); end
    rd(0, v); n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL alu_sub_self: got %0h expected 00", v); end
    rd(1, v); n_tests++;
    if (v !== 8'hFD) begin n_fail++; $display("FAIL alu_sub_wrap: got %0h expected fd", v); end
    run = 1'b0;
  endtask

  task automatic test_jz();
    int cyc, pul; bit to;
    apply_reset();
    clear_image(8'hFF);
    img[0] = enc(3, 0, 9);
    load_image();
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1; n_tests++;
    if (pc !== 8'd9) begin n_fail++; $display("FAIL jz_taken_pc: got %0h expected 09", pc); end
    wait_halt(cyc, pul, to);
    n_tests++;
    if (to || pc !== 8'd9) begin n_fail++; $display("FAIL jz_taken_halt: got pc=%0h to=%0b expected pc=09", pc, to); end
    run = 1'b0;

    apply_reset();
    clear_image(8'hFF);
    img[16] = 8'h05;
    img[0] = enc(0, 1, 0);
    img[1] = enc(3, 1, 9);
    load_image();
    run = 1'b1;
    repeat (5) @(posedge clk);
    #1; n_tests++;
    if (pc !== 8'd2) begin n_fail++; $display("FAIL jz_not_taken_pc: got %0h expected 02", pc); end
    run = 1'b0;
  endtask

  task automatic test_pause();
    logic [7:0] v;
    int cyc, pul; bit to;
    apply_reset();
    clear_image(8'hFF);
    img[16] = 8'd1; img[17] = 8'd2;
    img[0] = enc(0, 1, 0);
    img[1] = enc(0, 2, 1);
    img[2] = enc_alu(1, 2, 0);
    img[3] = enc_alu(1, 1, 0);
    img[4] = enc(1, 1, 15);
    img[5] = enc_alu(2, 1, 3);
    img[6] = enc_alu(2, 2, 2);
    model_run();
    load_image();
    run = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin prog_we = 1'b1; prog_addr = 5'd5; prog_wdata = 8'hFF; end
      if (k == 4) prog_we = 1'b0;
      if (k == 8) run = 1'b0;
    end
    n_tests++;
    if (busy !== 1'b0 || halted !== 1'b0 || pc !== 8'd4) begin
      n_fail++; $display("FAIL pause_state: got busy=%0b halted=%0b pc=%0h expected 0 0 04", busy, halted, pc);
    end
    rd(1, v); n_tests++;
    if (v !== 8'd6) begin n_fail++; $display("FAIL pause_instr_done: got %0h expected 06", v); end
    repeat (3) @(posedge clk);
    #1; n_tests++;
    if (pc !== 8'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL pause_hold: got pc=%0h busy=%0b expected 04 0", pc, busy); end
    @(negedge clk);
    run = 1'b1;
    wait_halt(cyc, pul, to);
    n_tests++;
    if (to || cyc !== 1 + 2 * (m_instrs - 4)) begin
      n_fail++; $display("FAIL resume_cycles: got %0d to=%0b expected %0d", cyc, to, 1 + 2 * (m_instrs - 4));
    end
    n_tests++;
    if (pc !== 8'(m_pc)) begin n_fail++; $display("FAIL resume_pc: got %0h expected %0h", pc, m_pc); end
    rd(2, v); n_tests++;
    if (v !== 8'(m_regs[2])) begin n_fail++; $display("FAIL resume_r2: got %0h expected %0h", v, m_regs[2]); end
    run = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    apply_reset();
    clear_image(8'hFF);
    img[16] = 8'hA5;
    img[0] = enc(0, 1, 0);
    img[1] = enc(1, 1, 15);
    load_image();
    run = 1'b1;
    repeat (6) @(posedge clk);
    #1; n_tests++;
    if (out_data !== 8'hA5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got out=%0h busy=%0b expected a5 1", out_data, busy);
    end
    #2 rst_n = 1'b0;
    #1; n_tests++;
    if (pc !== 8'h00 || busy !== 1'b0 || halted !== 1'b0 || out_data !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_outputs: got pc=%0h busy=%0b halted=%0b out=%0h ov=%0b expected zeros",
                         pc, busy, halted, out_data, out_valid);
    end
    rd(1, v); n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL areset_reg: got %0h expected 00", v); end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] v;
    int n, kind, ra, cyc, pul; bit to;
    for (int t = 0; t < 15; t++) begin
      apply_reset();
      clear_image(8'hFF);
      for (int i = 16; i < 32; i++)
        img[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      n = $urandom_range(3, 10);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 3);
        ra = $urandom_range(0, 3);
        case (kind)
          0: img[i] = enc(0, ra, $urandom_range(0, 15));
          1: img[i] = enc(1, ra, $urandom_range(0, 15));
          2: img[i] = enc_alu(ra, $urandom_range(0, 3), $urandom_range(0, 3));
          default: img[i] = enc(3, ra, $urandom_range(i + 1, 15));
        endcase
      end
      model_run();
      load_image();
      run = 1'b1;
      wait_halt(cyc, pul, to);
      n_tests++;
      if (to || cyc !== 1 + 2 * m_instrs) begin
        n_fail++; $display("FAIL rand%0d_cycles: got %0d to=%0b expected %0d", t, cyc, to, 1 + 2 * m_instrs);
      end
      n_tests++;
      if (pc !== 8'(m_pc)) begin n_fail++; $display("FAIL rand%0d_pc: got %0h expected %0h", t, pc, m_pc); end
      n_tests++;
      if (pul !== m_outcnt || out_data !== 8'(m_out)) begin
        n_fail++; $display("FAIL rand%0d_out: got %0d pulses data %0h expected %0d pulses data %0h",
                           t, pul, out_data, m_outcnt, m_out);
      end
      for (int r = 0; r < 4; r++) begin
        rd(r, v); n_tests++;
        if (v !== 8'(m_regs[r])) begin n_fail++; $display("FAIL rand%0d_r%0d: got %0h expected %0h", t, r, v, m_regs[r]); end
      end
      run = 1'b0;
    end
  endtask

  task automatic test_wide();
    logic [15:0] w [64];
    int pul, k; bit seen;
    apply_reset();
    for (int i = 0; i < 64; i++) w[i] = (i < 16) ? 16'h00FF : 16'h0000;
    w[32] = 16'hFFFF; w[33] = 16'h0001;
    w[0] = 16'(enc(0, 1, 0));
    w[1] = 16'(enc(0, 2, 1));
    w[2] = 16'(enc(1, 2, 15));
    w[3] = 16'(enc_alu(1, 2, 0));
    w[4] = 16'(enc(1, 1, 15));
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      w_prog_we = 1'b1; w_prog_addr = 6'(i); w_prog_wdata = w[i];
    end
    @(negedge clk);
    w_prog_we = 1'b0;
    w_run = 1'b1;
    pul = 0; seen = 1'b0; k = 0;
    while (k < 100 && !seen) begin
      @(posedge clk); #1;
      k++;
      if (w_out_valid) pul++;
      if (k == 7) begin
        n_tests++;
        if (w_out_data !== 16'h0001) begin n_fail++; $display("FAIL wide_st_r2: got %0h expected 0001", w_out_data); end
      end
      if (w_halted) seen = 1'b1;
    end
    n_tests++;
    if (!seen || w_pc !== 8'd5 || w_busy !== 1'b0) begin
      n_fail++; $display("FAIL wide_halt: got seen=%0b pc=%0h busy=%0b expected 1 05 0", seen, w_pc, w_busy);
    end
    w_dbg_sel = 2'd1;
    #1; n_tests++;
    if (w_dbg_rdata !== 16'h0000) begin n_fail++; $display("FAIL wide_add_wrap: got %0h expected 0000", w_dbg_rdata); end
    n_tests++;
    if (w_out_data !== 16'h0000 || pul !== 2) begin
      n_fail++; $display("FAIL wide_out: got %0h pulses %0d expected 0000 pulses 2", w_out_data, pul);
    end
    w_run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dbg_sel = 2'd0; w_dbg_sel = 2'd0;
    test_reset();
    test_single_step();
    test_alu();
    test_jz();
    test_pause();
    test_async_reset();
    test_random();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
